// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, memory and status signals of the shared data-memory arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              M0_REQ;
    logic              M0_WE;
    logic [ADDR_W-1:0] M0_ADDR;
    logic [DATA_W-1:0] M0_WDATA;
    logic              M0_GNT;
    logic              M0_RVALID;
    logic [DATA_W-1:0] M0_RDATA;

    logic              M1_REQ;
    logic              M1_WE;
    logic [ADDR_W-1:0] M1_ADDR;
    logic [DATA_W-1:0] M1_WDATA;
    logic              M1_GNT;
    logic              M1_RVALID;
    logic [DATA_W-1:0] M1_RDATA;

    logic              MEM_RD;
    logic              MEM_WRT;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;
    logic              BUSY;

    // The arbiter side
    modport slave (
        input  M0_REQ, M0_WE, M0_ADDR, M0_WDATA,
        input  M1_REQ, M1_WE, M1_ADDR, M1_WDATA,
        input  MEM_RDATA,
        output M0_GNT, M0_RVALID, M0_RDATA,
        output M1_GNT, M1_RVALID, M1_RDATA,
        output MEM_RD, MEM_WRT, MEM_ADDR, MEM_WDATA, BUSY
    );

    // Requesters plus memory, seen from outside the arbiter
    modport master (
        output M0_REQ, M0_WE, M0_ADDR, M0_WDATA,
        output M1_REQ, M1_WE, M1_ADDR, M1_WDATA,
        output MEM_RDATA,
        input  M0_GNT, M0_RVALID, M0_RDATA,
        input  M1_GNT, M1_RVALID, M1_RDATA,
        input  MEM_RD, MEM_WRT, MEM_ADDR, MEM_WDATA, BUSY
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin arbiter and single-word access sequencer for data memory
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic win0, win1;
    logic gnt0, gnt1;
    logic cap_rdata;
    logic mem_rd, mem_wrt;
    logic rvalid0, rvalid1;
    logic busy;

    // On a tie the requester that was not served last wins
    always_comb begin
        win0 = bus.M0_REQ & (~bus.M1_REQ | last_q);
        win1 = bus.M1_REQ & (~bus.M0_REQ | ~last_q);
        gnt0 = (state_q == IDLE) & RESET & win0;
        gnt1 = (state_q == IDLE) & RESET & win1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_rdata = 1'b0;
        mem_rd    = 1'b0;
        mem_wrt   = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (gnt0 | gnt1) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_rd  = ~we_q;
                mem_wrt = we_q;
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Counter reaching zero marks the cycle MEM_RDATA is valid
                if (cnt_q == 4'd0) begin
                    cap_rdata = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rvalid0 = ~owner_q;
                rvalid1 = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            if (gnt0 | gnt1) begin
                owner_q     <= gnt1;
                last_q      <= gnt1;
                we_q        <= gnt1 ? bus.M1_WE    : bus.M0_WE;
                mem_addr_q  <= gnt1 ? bus.M1_ADDR  : bus.M0_ADDR;
                mem_wdata_q <= gnt1 ? bus.M1_WDATA : bus.M0_WDATA;
            end
            if (cap_rdata) begin
                if (owner_q) begin
                    rdata1_q <= bus.MEM_RDATA;
                end else begin
                    rdata0_q <= bus.MEM_RDATA;
                end
            end
        end
    end

    always @(posedge CLK) begin
        lat_legal: assert (MEM_LAT >= 1 && MEM_LAT <= 15)
            else $error("dmem_arbiter: MEM_LAT=%0d is outside 1..15", MEM_LAT);
    end

    assign bus.M0_GNT    = gnt0;
    assign bus.M1_GNT    = gnt1;
    assign bus.M0_RVALID = rvalid0;
    assign bus.M1_RVALID = rvalid1;
    assign bus.M0_RDATA  = rdata0_q;
    assign bus.M1_RDATA  = rdata1_q;
    assign bus.MEM_RD    = mem_rd;
    assign bus.MEM_WRT   = mem_wrt;
    assign bus.MEM_ADDR  = mem_addr_q;
    assign bus.MEM_WDATA = mem_wdata_q;
    assign bus.BUSY      = busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven and directed-sequence bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam logic [31:0] Z   = 32'h0;
    localparam logic [31:0] DB  = 32'hDEADBEEF;
    localparam logic [31:0] W30 = 32'hC0DE0030;
    localparam logic [31:0] W40 = 32'hC0DE0040;

    typedef struct {
        logic        rst_n;
        logic        req0, we0;
        logic [31:0] addr0, wd0;
        logic        req1, we1;
        logic [31:0] addr1, wd1;
        logic [1:0]  gnt, rv;
        logic        rd, wrt, busy;
        logic [31:0] maddr, mwdata, rdata0, rdata1;
    } vec_t;

    logic CLK;
    logic RESET;
    int   cyc;
    int   total;
    int   bad;
    int   excl_viol;
    int   due0, due1;
    logic [31:0] ad0, ad1;
    vec_t vecs[$];

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT0)) dut0 (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus0.slave)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1)) dut1 (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus1.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return DB;
        if (a == 32'h4)  return 32'hA5A5A5A5;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory models: data valid only in the cycle MEM_LAT after the read strobe
    always @(negedge CLK) begin
        if (bus0.MEM_RD) begin
            due0 = cyc + LAT0;
            ad0  = bus0.MEM_ADDR;
        end
        bus0.MEM_RDATA = (cyc == due0) ? mem_word(ad0) : 32'hBAD0BAD0;
        if (bus1.MEM_RD) begin
            due1 = cyc + LAT1;
            ad1  = bus1.MEM_ADDR;
        end
        bus1.MEM_RDATA = (cyc == due1) ? mem_word(ad1) : 32'hBAD0BAD0;
    end

    always @(negedge CLK) begin
        #3;
        if (RESET === 1'b1) begin
            if ((bus0.MEM_RD & bus0.MEM_WRT) | (bus0.M0_GNT & bus0.M1_GNT) |
                (bus0.M0_RVALID & bus0.M1_RVALID)) excl_viol++;
            if ((bus1.MEM_RD & bus1.MEM_WRT) | (bus1.M0_GNT & bus1.M1_GNT) |
                (bus1.M0_RVALID & bus1.M1_RVALID)) excl_viol++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst_n, input logic req0, input logic we0,
                       input logic [31:0] addr0, input logic [31:0] wd0,
                       input logic req1, input logic we1,
                       input logic [31:0] addr1, input logic [31:0] wd1,
                       input logic [1:0] gnt, input logic [1:0] rv,
                       input logic rd, input logic wrt, input logic busy,
                       input logic [31:0] maddr, input logic [31:0] mwdata,
                       input logic [31:0] rdata0, input logic [31:0] rdata1);
        vec_t v;
        v.rst_n = rst_n; v.req0 = req0; v.we0 = we0; v.addr0 = addr0; v.wd0 = wd0;
        v.req1 = req1; v.we1 = we1; v.addr1 = addr1; v.wd1 = wd1;
        v.gnt = gnt; v.rv = rv; v.rd = rd; v.wrt = wrt; v.busy = busy;
        v.maddr = maddr; v.mwdata = mwdata; v.rdata0 = rdata0; v.rdata1 = rdata1;
        vecs.push_back(v);
    endtask

    task automatic drive0(input logic req0, input logic we0, input logic [31:0] addr0,
                          input logic req1, input logic we1, input logic [31:0] addr1,
                          input logic [31:0] wd1);
        bus0.M0_REQ = req0; bus0.M0_WE = we0; bus0.M0_ADDR = addr0; bus0.M0_WDATA = Z;
        bus0.M1_REQ = req1; bus0.M1_WE = we1; bus0.M1_ADDR = addr1; bus0.M1_WDATA = wd1;
    endtask

    initial begin
        int g0_cnt, g1_evt, last_g, gap_bad;
        total = 0; bad = 0; excl_viol = 0;
        due0 = -100; due1 = -100; ad0 = Z; ad1 = Z;
        RESET = 1'b0;
        drive0(1'b0, 1'b0, Z, 1'b0, 1'b0, Z, Z);
        bus1.M0_REQ = 1'b0; bus1.M0_WE = 1'b0; bus1.M0_ADDR = Z; bus1.M0_WDATA = Z;
        bus1.M1_REQ = 1'b0; bus1.M1_WE = 1'b0; bus1.M1_ADDR = Z; bus1.M1_WDATA = Z;
        repeat (2) @(posedge CLK);

        // Reset state, with both requesting: grants must stay low
        @(negedge CLK);
        drive0(1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h20, Z);
        #1;
        chk("rst_gnt",  {30'd0, bus0.M1_GNT, bus0.M0_GNT}, 32'd0);
        chk("rst_busy", {31'd0, bus0.BUSY}, 32'd0);
        chk("rst_rv",   {30'd0, bus0.M1_RVALID, bus0.M0_RVALID}, 32'd0);
        chk("rst_strb", {30'd0, bus0.MEM_RD, bus0.MEM_WRT}, 32'd0);
        chk("rst_maddr", bus0.MEM_ADDR, Z);
        chk("rst_rdata0", bus0.M0_RDATA, Z);

        //   rst  r0   w0   a0      wd0 r1   w1   a1      wd1          gnt    rv     rd   wrt  busy maddr   mwdata        rdata0 rdata1
        add(1'b1, 1'b1,1'b0,32'h10, Z, 1'b0,1'b0,Z,      Z,           2'b01,2'b00, 1'b0,1'b0,1'b0, Z,      Z,            Z,   Z);
        add(1'b1, 1'b0,1'b0,Z,      Z, 1'b0,1'b0,Z,      Z,           2'b00,2'b00, 1'b1,1'b0,1'b1, 32'h10, Z,            Z,   Z);
        add(1'b1, 1'b0,1'b0,Z,      Z, 1'b0,1'b0,Z,      Z,           2'b00,2'b00, 1'b0,1'b0,1'b1, 32'h10, Z,            Z,   Z);
        add(1'b1, 1'b0,1'b0,Z,      Z, 1'b0,1'b0,Z,      Z,           2'b00,2'b00, 1'b0,1'b0,1'b1, 32'h10, Z,            Z,   Z);
        add(1'b1, 1'b0,1'b0,Z,      Z, 1'b0,1'b0,Z,      Z,           2'b00,2'b01, 1'b0,1'b0,1'b1, 32'h10, Z,            DB,  Z);
        add(1'b1, 1'b0,1'b0,Z,      Z, 1'b1,1'b1,32'h20, 32'h12345678,2'b10,2'b00, 1'b0,1'b0,1'b0, 32'h10, Z,            DB,  Z);
        add(1'b1, 1'b0,1'b0,Z,      Z, 1'b0,1'b0,Z,      Z,           2'b00,2'b00, 1'b0,1'b1,1'b1, 32'h20, 32'h12345678, DB,  Z);
        add(1'b1, 1'b0,1'b0,Z,      Z, 1'b0,1'b0,Z,      Z,           2'b00,2'b10, 1'b0,1'b0,1'b1, 32'h20, 32'h12345678, DB,  Z);
        add(1'b1, 1'b1,1'b0,32'h30, Z, 1'b1,1'b0,32'h40, Z,           2'b01,2'b00, 1'b0,1'b0,1'b0, 32'h20, 32'h12345678, DB,  Z);
        add(1'b1, 1'b1,1'b0,32'h30, Z, 1'b1,1'b0,32'h40, Z,           2'b00,2'b00, 1'b1,1'b0,1'b1, 32'h30, Z,            DB,  Z);
        add(1'b1, 1'b1,1'b0,32'h30, Z, 1'b1,1'b0,32'h40, Z,           2'b00,2'b00, 1'b0,1'b0,1'b1, 32'h30, Z,            DB,  Z);
        add(1'b1, 1'b1,1'b0,32'h30, Z, 1'b1,1'b0,32'h40, Z,           2'b00,2'b00, 1'b0,1'b0,1'b1, 32'h30, Z,            DB,  Z);
        add(1'b1, 1'b1,1'b0,32'h30, Z, 1'b1,1'b0,32'h40, Z,           2'b00,2'b01, 1'b0,1'b0,1'b1, 32'h30, Z,            W30, Z);
        add(1'b1, 1'b1,1'b0,32'h30, Z, 1'b1,1'b0,32'h40, Z,           2'b10,2'b00, 1'b0,1'b0,1'b0, 32'h30, Z,            W30, Z);
        add(1'b1, 1'b1,1'b0,32'h30, Z, 1'b1,1'b0,32'h40, Z,           2'b00,2'b00, 1'b1,1'b0,1'b1, 32'h40, Z,            W30, Z);
        add(1'b1, 1'b1,1'b0,32'h30, Z, 1'b1,1'b0,32'h40, Z,           2'b00,2'b00, 1'b0,1'b0,1'b1, 32'h40, Z,            W30, Z);
        add(1'b1, 1'b1,1'b0,32'h30, Z, 1'b1,1'b0,32'h40, Z,           2'b00,2'b00, 1'b0,1'b0,1'b1, 32'h40, Z,            W30, Z);
        add(1'b1, 1'b1,1'b0,32'h30, Z, 1'b1,1'b0,32'h40, Z,           2'b00,2'b10, 1'b0,1'b0,1'b1, 32'h40, Z,            W30, W40);
        add(1'b1, 1'b1,1'b0,32'h30, Z, 1'b1,1'b0,32'h40, Z,           2'b01,2'b00, 1'b0,1'b0,1'b0, 32'h40, Z,            W30, W40);

        foreach (vecs[i]) begin
            @(negedge CLK);
            RESET = vecs[i].rst_n;
            drive0(vecs[i].req0, vecs[i].we0, vecs[i].addr0,
                   vecs[i].req1, vecs[i].we1, vecs[i].addr1, vecs[i].wd1);
            bus0.M0_WDATA = vecs[i].wd0;
            #1;
            chk($sformatf("v%0d_gnt", i),  {30'd0, bus0.M1_GNT, bus0.M0_GNT}, {30'd0, vecs[i].gnt});
            chk($sformatf("v%0d_rv", i),   {30'd0, bus0.M1_RVALID, bus0.M0_RVALID}, {30'd0, vecs[i].rv});
            chk($sformatf("v%0d_strb", i), {30'd0, bus0.MEM_RD, bus0.MEM_WRT}, {30'd0, vecs[i].rd, vecs[i].wrt});
            chk($sformatf("v%0d_busy", i), {31'd0, bus0.BUSY}, {31'd0, vecs[i].busy});
            chk($sformatf("v%0d_maddr", i),  bus0.MEM_ADDR,  vecs[i].maddr);
            chk($sformatf("v%0d_mwdata", i), bus0.MEM_WDATA, vecs[i].mwdata);
            chk($sformatf("v%0d_rdata0", i), bus0.M0_RDATA,  vecs[i].rdata0);
            chk($sformatf("v%0d_rdata1", i), bus0.M1_RDATA,  vecs[i].rdata1);
        end

        // Reset in WAIT of an M0 read: abandoned, then M0 wins the first tie
        @(negedge CLK); #1;
        chk("rw_issue", {31'd0, bus0.MEM_RD}, 32'd1);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rw_wait_busy", {31'd0, bus0.BUSY}, 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("rw_busy",   {31'd0, bus0.BUSY}, 32'd0);
        chk("rw_rv",     {30'd0, bus0.M1_RVALID, bus0.M0_RVALID}, 32'd0);
        chk("rw_rdata0", bus0.M0_RDATA, Z);
        chk("rw_rdata1", bus0.M1_RDATA, Z);
        chk("rw_maddr",  bus0.MEM_ADDR, Z);
        chk("rw_gnt",    {30'd0, bus0.M1_GNT, bus0.M0_GNT}, 32'd1);
        @(negedge CLK);
        drive0(1'b0, 1'b0, Z, 1'b0, 1'b0, Z, Z);
        #1;
        chk("rw_rv2",    {30'd0, bus0.M1_RVALID, bus0.M0_RVALID}, 32'd0);
        chk("rw_maddr2", bus0.MEM_ADDR, 32'h30);
        repeat (3) @(negedge CLK);
        #1;
        chk("rw_resp_rv", {30'd0, bus0.M1_RVALID, bus0.M0_RVALID}, 32'd1);
        chk("rw_resp_d",  bus0.M0_RDATA, W30);

        // M0 requesting alone: one grant every 3+LAT0 cycles, nothing for M1
        g0_cnt = 0; g1_evt = 0; last_g = -1; gap_bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            drive0(1'b1, 1'b0, 32'h50, 1'b0, 1'b0, Z, Z);
            #1;
            if (bus0.M0_GNT) begin
                if (last_g >= 0 && (k - last_g) != 3 + LAT0) gap_bad++;
                last_g = k;
                g0_cnt++;
            end
            if (bus0.M1_GNT | bus0.M1_RVALID) g1_evt++;
        end
        chk("solo_grants", g0_cnt, 4);
        chk("solo_gaps",   gap_bad, 0);
        chk("solo_m1",     g1_evt, 0);
        chk("solo_first",  last_g, 15);
        @(negedge CLK);
        drive0(1'b0, 1'b0, Z, 1'b0, 1'b0, Z, Z);

        // MEM_LAT=1 build: M1 read of 0x4
        @(negedge CLK);
        bus1.M1_REQ = 1'b1; bus1.M1_WE = 1'b0; bus1.M1_ADDR = 32'h4;
        #1;
        chk("l1_gnt", {30'd0, bus1.M1_GNT, bus1.M0_GNT}, 32'd2);
        @(negedge CLK);
        bus1.M1_REQ = 1'b0; bus1.M1_ADDR = Z;
        #1;
        chk("l1_rd",    {31'd0, bus1.MEM_RD}, 32'd1);
        chk("l1_maddr", bus1.MEM_ADDR, 32'h4);
        @(negedge CLK); #1;
        chk("l1_rv_early", {30'd0, bus1.M1_RVALID, bus1.M0_RVALID}, 32'd0);
        @(negedge CLK); #1;
        chk("l1_rv",    {30'd0, bus1.M1_RVALID, bus1.M0_RVALID}, 32'd2);
        chk("l1_rdata", bus1.M1_RDATA, 32'hA5A5A5A5);
        @(negedge CLK); #1;
        chk("l1_idle",  {31'd0, bus1.BUSY}, 32'd0);

        chk("exclusive", excl_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer for the shared data memory.
- Requester 0 is the core load/store path; requester 1 is the DMA/debug loader port.
- Serialises single-word reads and writes onto one memory port and returns responses to the owning requester.
- Sits between the requesters and the DataMemory instance; the memory has a fixed read latency.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the MEM_RD issue cycle until MEM_RDATA is valid; legal range 1..15.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-low reset; RESET=0 resets at the next rising CLK.
- M0_REQ  in  1  requester 0 request; held high until M0_GNT is seen.
- M0_WE  in  1  1 = write, 0 = read.
- M0_ADDR  in  ADDR_W  word address.
- M0_WDATA  in  DATA_W  write data.
- M0_GNT  out  1  combinational grant; the command is accepted on this edge.
- M0_RVALID  out  1  one-cycle response pulse; a write acknowledge or read data valid.
- M0_RDATA  out  DATA_W  read data; meaningful when M0_RVALID=1 for a read.
- M1_REQ, M1_WE, M1_ADDR, M1_WDATA, M1_GNT, M1_RVALID, M1_RDATA: same as requester 0, for requester 1.
- MEM_RD  out  1  memory read strobe, one cycle.
- MEM_WRT  out  1  memory write strobe, one cycle.
- MEM_ADDR  out  ADDR_W  registered memory address.
- MEM_WDATA  out  DATA_W  registered memory write data.
- MEM_RDATA  in  DATA_W  memory read data.
- BUSY  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grants are issued only here. GNTx = IDLE & RESET & winner.
  - Winner: the single requester if only one is asserting REQ.
  - If both request, the requester other than LAST wins. LAST is the round-robin pointer and resets to 1, so M0 wins the first tie.
  - On a grant edge: latch ADDR/WDATA/WE into MEM_ADDR/MEM_WDATA/op, record OWNER, set LAST=OWNER, go to ISSUE.
  - A REQ withdrawn before its grant is simply not served.
- ISSUE (exactly 1 cycle):
  - MEM_RD=1 for a read or MEM_WRT=1 for a write.
  - Read: load counter with MEM_LAT-1, go to WAIT.
  - Write: go to RESP.
- WAIT (MEM_LAT cycles):
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, MEM_RDATA is valid. Register it into OWNER's RDATA and go to RESP.
- RESP (1 cycle):
  - OWNER's RVALID=1; the other requester's RVALID=0.
  - Go to IDLE.
- Timing relative to the grant cycle 0:
  - Read: MEM_RD in cycle 1, data sampled in cycle 1+MEM_LAT, RVALID in cycle 2+MEM_LAT, next grant possible in cycle 3+MEM_LAT.
  - Write: MEM_WRT in cycle 1, RVALID in cycle 2, next grant possible in cycle 3.
- Output holding:
  - Mx_RDATA holds its value until that requester's next read response; it is not updated by writes.
  - MEM_ADDR/MEM_WDATA hold their last value when idle.
- Reset (RESET=0 sampled at an edge, from any state):
  - State becomes IDLE, LAST=1, counter=0.
  - MEM_RD, MEM_WRT, RVALIDs, BUSY = 0; MEM_ADDR, MEM_WDATA, RDATAs = 0.
  - GNTs are forced to 0 while RESET=0.
  - An in-flight access is abandoned with no RVALID.
- Strobes are never both high. At most one GNT and at most one RVALID are high per cycle.
- MEM_LAT outside 1..15 is illegal; flag it with a simulation-time error.

Test Plan:
- M0 read, addr 0x10, MEM_LAT=2, memory returns 0xDEADBEEF in cycle 3 -> M0_GNT cycle 0, MEM_RD=1 with MEM_ADDR=0x10 in cycle 1, M0_RVALID=1 with M0_RDATA=0xDEADBEEF in cycle 4, BUSY high in cycles 1-4.
- M1 write, addr 0x20, data 0x12345678 -> M1_GNT cycle 0, MEM_WRT=1 with MEM_ADDR=0x20 and MEM_WDATA=0x12345678 in cycle 1, M1_RVALID in cycle 2, M1_RDATA unchanged.
- Both request reads continuously from reset -> grants alternate M0, M1, M0, M1; each RVALID goes only to its owner; grants are 5 cycles apart for MEM_LAT=2.
- M0 requests alone continuously -> M0 granted every 5 cycles; M1_GNT and M1_RVALID never assert.
- RESET=0 during WAIT of an M0 read -> next cycle state IDLE, BUSY=0, no M0_RVALID, RDATA=0; with both requesting after release, M0 is granted first.
- MEM_LAT=1 build, M1 read of 0x4 returning 0xA5A5A5A5 -> MEM_RD in cycle 1, RVALID in cycle 3 with M1_RDATA=0xA5A5A5A5.
